bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Downstream consumer of the egg-timer set/run FSM. Latches the MM:SS BCD preset while loading is enabled, then counts down once per 1 Hz tick while countdown is enabled. On reaching 00:00 it raises cook_time, which returns the FSM to set-time, and drives a timed alarm. Its digit outputs feed the seven-segment display multiplexer.

Parameters:
ALARM_TICKS, 5, number of tick_1hz periods the alarm output stays high after expiry (1..15).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
tick_1hz  input  1  single-clk-wide enable pulse, once per second
enable_load  input  1  FSM in set-time; preset digits are tracked
enable_countdown  input  1  FSM in run state; countdown permitted
load_sec_ones  input  4  preset seconds ones, BCD
load_sec_tens  input  4  preset seconds tens, BCD
load_min_ones  input  4  preset minutes ones, BCD
load_min_tens  input  4  preset minutes tens, BCD
sec_ones  output  4  current seconds ones
sec_tens  output  4  current seconds tens
min_ones  output  4  current minutes ones
min_tens  output  4  current minutes tens
cook_time  output  1  level; high while time expired (state DONE)
alarm  output  1  high for ALARM_TICKS seconds after expiry
timer_state  output  2  current state encoding, for debug/LEDs

Behaviour:
- Reset (async): state=IDLE, all digits=0, cook_time=0, alarm=0, alarm counter=0.
- States: IDLE=2'd0, COUNTING=2'd1, DONE=2'd2. 2'd3 is illegal and goes to IDLE on the next clk.
- Priority in every state: enable_load over enable_countdown over tick_1hz.
- IDLE:
  - If enable_load, the digits register the preset every clk. One-cycle latency; the digits track the preset continuously.
  - If enable_countdown=1 and enable_load=0: go to DONE if the digits are 00:00, otherwise go to COUNTING.
  - A tick on the entry cycle is ignored.
- Load clamping: any ones digit >9 loads as 9; any tens digit >5 loads as 5. Min_tens is also limited to 5. Maximum count is 59:59.
- COUNTING:
  - On each tick_1hz, decrement MM:SS by one second with BCD borrow:
    - sec_ones 0 becomes 9 and borrows.
    - sec_tens 0 becomes 5 and borrows.
    - min_ones 0 becomes 9 and borrows.
    - min_tens then decrements.
  - If the decrement result is 00:00, move to DONE in that same clk. The digits show 00:00, and cook_time and alarm go high on the next cycle (registered with the digits).
  - If enable_load=1: abort. Go to IDLE and register the preset in the same clk.
  - If enable_countdown drops (with enable_load=0): hold the digits, stay in COUNTING, and ignore ticks until enable_countdown returns (pause).
- DONE:
  - Digits hold 00:00 and cook_time=1.
  - Alarm is 1 on entry. The alarm counter increments on each tick; alarm clears when the count reaches ALARM_TICKS and stays 0 thereafter.
  - If enable_load=1: go to IDLE, cook_time=0, alarm=0, counter=0, and register the preset.
  - enable_countdown is ignored in DONE.
- Reset asserted mid-operation overrides everything immediately, with no glitch-free requirement on outputs.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package egg_timer_pkg:
  - state encodings IDLE/COUNTING/DONE;
  - BCD limit constants DIGIT_MAX_ONES=9, DIGIT_MAX_TENS=5.
- One sub-module, bcd_digit_down: a 4-bit BCD down-digit.
  - Inputs: dec_en, max value.
  - Outputs: next digit, borrow_out, is_zero.
  - Instantiated four times, chained by borrow.
- The top level holds the FSM, load clamping and the alarm counter.

Test Plan:
- Countdown with borrow: load 01:05, enable_countdown, 6 ticks -> 00:59. 65 ticks total -> 00:00, cook_time=1, timer_state=2.
- Zero preset: load 00:00, enable_countdown -> DONE within 2 clks, cook_time=1, no decrement underflow (digits stay 00:00 after further ticks).
- Full range: load 59:59 then 3599 ticks -> 00:00. Check the 10:00 -> 09:59 step and the 50:00 -> 49:59 step.
- Abort, pause and priority:
  - Enable_load asserted after 3 ticks from 02:00 -> IDLE, digits = new preset 00:30 next clk.
  - Dropping enable_countdown for 4 ticks -> digits frozen.
  - Tick coincident with enable_load -> no decrement.
- Alarm and clamp:
  - ALARM_TICKS=5: alarm high exactly 5 ticks after expiry, then 0 while cook_time stays 1.
  - Load 4'hF/4'h7 presets -> digits clamp to 9/5.
- Reset mid-count at 00:42 -> all digits 0, cook_time=0, alarm=0, state IDLE immediately (async).

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg-timer countdown datapath: state encoding,
// BCD digit limits and the preset clamping helper.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2,
        ILLEGAL  = 2'd3
    } timer_state_t;

    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    // Out-of-range preset digits saturate at the digit's limit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] digit,
                                               input logic [3:0] max_value);
        return (digit > max_value) ? max_value : digit;
    endfunction

    function automatic bcd_time_t clamp_time(input bcd_time_t raw);
        bcd_time_t result;
        result.min_tens = clamp_digit(raw.min_tens, DIGIT_MAX_TENS);
        result.min_ones = clamp_digit(raw.min_ones, DIGIT_MAX_ONES);
        result.sec_tens = clamp_digit(raw.sec_tens, DIGIT_MAX_TENS);
        result.sec_ones = clamp_digit(raw.sec_ones, DIGIT_MAX_ONES);
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: wraps from 0 to max_value and raises
// borrow_out so the next more significant digit decrements.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic       dec_en,
    input  logic [3:0] max_value,
    output logic [3:0] next_digit,
    output logic       borrow_out,
    output logic       is_zero
);

    assign is_zero    = (digit == 4'd0);
    assign borrow_out = dec_en & is_zero;

    always_comb begin
        if (!dec_en) begin
            next_digit = digit;
        end else if (is_zero) begin
            next_digit = max_value;
        end else begin
            next_digit = digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: tracks the preset while loading, counts down on
// 1 Hz ticks while running, then holds cook_time and a timed alarm at 00:00.
module bcd_countdown_timer
    import egg_timer_pkg::*;
#(
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       enable_load,
    input  logic       enable_countdown,
    input  logic [3:0] load_sec_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_min_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       cook_time,
    output logic       alarm,
    output logic [1:0] timer_state
);

    localparam logic [3:0] ALARM_LIMIT = 4'(ALARM_TICKS);

    timer_state_t state, next_state;
    bcd_time_t    digits, digits_next, preset, dec_value;
    logic         cook_next, alarm_next;
    logic [3:0]   alarm_cnt, alarm_cnt_next;

    logic dec_go, all_zero, expiry;
    logic borrow_so, borrow_st, borrow_mo, borrow_mt;
    logic zero_so, zero_st, zero_mo, zero_mt;

    assign preset = clamp_time({load_min_tens, load_min_ones, load_sec_tens, load_sec_ones});

    assign all_zero = zero_so & zero_st & zero_mo & zero_mt;
    assign dec_go   = (state == COUNTING) & ~enable_load & enable_countdown
                    & tick_1hz & ~all_zero;

    // The min_tens borrow can only fire from 00:00, which dec_go excludes.
    assign expiry = dec_go & (dec_value == '0) & ~borrow_mt;

    bcd_digit_down u_sec_ones (
        .digit      (digits.sec_ones),
        .dec_en     (dec_go),
        .max_value  (DIGIT_MAX_ONES),
        .next_digit (dec_value.sec_ones),
        .borrow_out (borrow_so),
        .is_zero    (zero_so)
    );

    bcd_digit_down u_sec_tens (
        .digit      (digits.sec_tens),
        .dec_en     (borrow_so),
        .max_value  (DIGIT_MAX_TENS),
        .next_digit (dec_value.sec_tens),
        .borrow_out (borrow_st),
        .is_zero    (zero_st)
    );

    bcd_digit_down u_min_ones (
        .digit      (digits.min_ones),
        .dec_en     (borrow_st),
        .max_value  (DIGIT_MAX_ONES),
        .next_digit (dec_value.min_ones),
        .borrow_out (borrow_mo),
        .is_zero    (zero_mo)
    );

    bcd_digit_down u_min_tens (
        .digit      (digits.min_tens),
        .dec_en     (borrow_mo),
        .max_value  (DIGIT_MAX_TENS),
        .next_digit (dec_value.min_tens),
        .borrow_out (borrow_mt),
        .is_zero    (zero_mt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch
        // is inferred.
        next_state = state;
        case (state)
            IDLE: begin
                if (enable_load) begin
                    next_state = IDLE;
                end else if (enable_countdown) begin
                    next_state = all_zero ? DONE : COUNTING;
                end
            end
            COUNTING: begin
                if (enable_load) begin
                    next_state = IDLE;
                end else if (expiry) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (enable_load) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values for the registered outputs and the alarm counter.
    always_comb begin
        digits_next    = digits;
        cook_next      = cook_time;
        alarm_next     = alarm;
        alarm_cnt_next = alarm_cnt;
        case (state)
            IDLE: begin
                if (enable_load) begin
                    digits_next = preset;
                end else if (enable_countdown && all_zero) begin
                    cook_next      = 1'b1;
                    alarm_next     = 1'b1;
                    alarm_cnt_next = 4'd0;
                end
            end
            COUNTING: begin
                if (enable_load) begin
                    digits_next = preset;
                end else if (dec_go) begin
                    digits_next = dec_value;
                    if (expiry) begin
                        cook_next      = 1'b1;
                        alarm_next     = 1'b1;
                        alarm_cnt_next = 4'd0;
                    end
                end
            end
            DONE: begin
                if (enable_load) begin
                    digits_next    = preset;
                    cook_next      = 1'b0;
                    alarm_next     = 1'b0;
                    alarm_cnt_next = 4'd0;
                end else if (tick_1hz && (alarm_cnt < ALARM_LIMIT)) begin
                    // Counter saturates at the limit so the alarm stays off.
                    alarm_cnt_next = alarm_cnt + 4'd1;
                    if ((alarm_cnt + 4'd1) == ALARM_LIMIT) begin
                        alarm_next = 1'b0;
                    end
                end
            end
            default: begin
                cook_next      = 1'b0;
                alarm_next     = 1'b0;
                alarm_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits    <= '0;
            cook_time <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= 4'd0;
        end else begin
            digits    <= digits_next;
            cook_time <= cook_next;
            alarm     <= alarm_next;
            alarm_cnt <= alarm_cnt_next;
        end
    end

    assign sec_ones    = digits.sec_ones;
    assign sec_tens    = digits.sec_tens;
    assign min_ones    = digits.min_ones;
    assign min_tens    = digits.min_tens;
    assign timer_state = state;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random
// stimulus against a seconds-based reference model.
module tb_bcd_countdown_timer;

    localparam int ALARM_TICKS = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz, enable_load, enable_countdown;
    logic [3:0] load_sec_ones, load_sec_tens, load_min_ones, load_min_tens;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       cook_time, alarm;
    logic [1:0] timer_state;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining time as plain seconds, mode 0/1/2, ticks since expiry.
    int m_mode;
    int m_total;
    int m_ticks_done;

    bcd_countdown_timer #(.ALARM_TICKS(ALARM_TICKS)) dut (
        .clk              (clk),
        .reset            (reset),
        .tick_1hz         (tick_1hz),
        .enable_load      (enable_load),
        .enable_countdown (enable_countdown),
        .load_sec_ones    (load_sec_ones),
        .load_sec_tens    (load_sec_tens),
        .load_min_ones    (load_min_ones),
        .load_min_tens    (load_min_tens),
        .sec_ones         (sec_ones),
        .sec_tens         (sec_tens),
        .min_ones         (min_ones),
        .min_tens         (min_tens),
        .cook_time        (cook_time),
        .alarm            (alarm),
        .timer_state      (timer_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lim(input int d, input int max_value);
        return (d > max_value) ? max_value : d;
    endfunction

    function automatic int preset_seconds();
        int minutes, seconds;
        minutes = lim(int'(load_min_tens), 5) * 10 + lim(int'(load_min_ones), 9);
        seconds = lim(int'(load_sec_tens), 5) * 10 + lim(int'(load_sec_ones), 9);
        return minutes * 60 + seconds;
    endfunction

    function automatic logic [15:0] to_bcd(input int t);
        return {4'(t / 600), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10)};
    endfunction

    function automatic logic [31:0] got_vec();
        return {12'd0, min_tens, min_ones, sec_tens, sec_ones, cook_time, alarm, timer_state};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic cook_e, alarm_e;
        cook_e  = (m_mode == 2);
        alarm_e = (m_mode == 2) && (m_ticks_done < ALARM_TICKS);
        return {12'd0, to_bcd(m_total), cook_e, alarm_e, 2'(m_mode)};
    endfunction

    function automatic logic [31:0] got_digits();
        return {16'd0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_total      = 0;
        m_ticks_done = 0;
    endtask

    task automatic model_clk(input bit ld, input bit cd, input bit tk);
        int pre;
        pre = preset_seconds();
        if (ld) begin
            m_mode       = 0;
            m_total      = pre;
            m_ticks_done = 0;
        end else if (m_mode == 0) begin
            if (cd) begin
                m_mode       = (m_total == 0) ? 2 : 1;
                m_ticks_done = 0;
            end
        end else if (m_mode == 1) begin
            if (cd && tk) begin
                m_total = m_total - 1;
                if (m_total == 0) begin
                    m_mode       = 2;
                    m_ticks_done = 0;
                end
            end
        end else begin
            if (tk) m_ticks_done++;
        end
    endtask

    task automatic step(input bit ld, input bit cd, input bit tk);
        enable_load      = ld;
        enable_countdown = cd;
        tick_1hz         = tk;
        @(posedge clk);
        model_clk(ld, cd, tk);
        #1;
        check("cycle", got_vec(), exp_vec());
    endtask

    task automatic pulse_ticks(input int n, input bit cd);
        for (int i = 0; i < n; i++) begin
            step(1'b0, cd, 1'b1);
            step(1'b0, cd, 1'b0);
        end
    endtask

    task automatic set_preset(input logic [3:0] mt, input logic [3:0] mo,
                              input logic [3:0] st, input logic [3:0] so);
        load_min_tens = mt;
        load_min_ones = mo;
        load_sec_tens = st;
        load_sec_ones = so;
    endtask

    initial begin
        reset = 1'b1;
        enable_load = 1'b0;
        enable_countdown = 1'b0;
        tick_1hz = 1'b0;
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", got_vec(), 32'd0);
        reset = 1'b0;

        // Countdown with borrow from 01:05.
        set_preset(4'd0, 4'd1, 4'd0, 4'd5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("load_0105", got_digits(), 32'h0105);
        step(1'b0, 1'b1, 1'b0);
        check("enter_counting", 32'(timer_state), 32'd1);
        pulse_ticks(6, 1'b1);
        check("borrow_0059", got_digits(), 32'h0059);
        pulse_ticks(59, 1'b1);
        check("expired_digits", got_digits(), 32'h0000);
        check("expired_state", {29'd0, cook_time, timer_state}, {29'd0, 1'b1, 2'd2});
        check("alarm_on_entry", 32'(alarm), 32'd1);
        pulse_ticks(ALARM_TICKS - 1, 1'b1);
        check("alarm_still_on", 32'(alarm), 32'd1);
        pulse_ticks(1, 1'b1);
        check("alarm_cleared", {30'd0, cook_time, alarm}, {30'd0, 1'b1, 1'b0});
        pulse_ticks(3, 1'b0);
        check("alarm_stays_off", 32'(alarm), 32'd0);

        // Zero preset goes straight to DONE without underflow.
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0);
        check("exit_done", {29'd0, cook_time, timer_state}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("zero_done", {29'd0, cook_time, timer_state}, {29'd0, 1'b1, 2'd2});
        pulse_ticks(3, 1'b1);
        check("zero_no_underflow", got_digits(), 32'h0000);

        // Full range 59:59 down to 00:00.
        set_preset(4'd5, 4'd9, 4'd5, 4'd9);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3599; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (m_total == 3000) check("step_5000", got_digits(), 32'h5000);
            if (m_total == 2999) check("step_4959", got_digits(), 32'h4959);
            if (m_total == 600)  check("step_1000", got_digits(), 32'h1000);
            if (m_total == 599)  check("step_0959", got_digits(), 32'h0959);
            step(1'b0, 1'b1, 1'b0);
        end
        check("full_range_done", {16'd0, got_digits()[15:0] | {14'd0, timer_state}}, 32'd2);

        // Abort with a tick coincident with enable_load.
        set_preset(4'd0, 4'd2, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        pulse_ticks(3, 1'b1);
        check("abort_pre", got_digits(), 32'h0157);
        set_preset(4'd0, 4'd0, 4'd3, 4'd0);
        step(1'b1, 1'b1, 1'b1);
        check("abort_digits", got_digits(), 32'h0030);
        check("abort_state", 32'(timer_state), 32'd0);

        // Pause: ticks ignored while enable_countdown is low.
        set_preset(4'd0, 4'd2, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        pulse_ticks(2, 1'b1);
        pulse_ticks(4, 1'b0);
        check("pause_hold", {16'd0, got_digits()[15:0]}, 32'h0158);
        check("pause_state", 32'(timer_state), 32'd1);
        pulse_ticks(1, 1'b1);
        check("resume", got_digits(), 32'h0157);

        // Load clamping.
        set_preset(4'h7, 4'hF, 4'h7, 4'hF);
        step(1'b1, 1'b0, 1'b0);
        check("clamp_a", got_digits(), 32'h5959);
        set_preset(4'hF, 4'h3, 4'h6, 4'h2);
        step(1'b1, 1'b0, 1'b0);
        check("clamp_b", got_digits(), 32'h5352);

        // Asynchronous reset mid-count at 00:42.
        set_preset(4'd0, 4'd0, 4'd4, 4'd5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        pulse_ticks(3, 1'b1);
        check("pre_reset", got_digits(), 32'h0042);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", got_vec(), 32'd0);
        model_reset();
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            bit ld, cd, tk;
            set_preset(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                       4'($urandom_range(0, 2)),
                       4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
            ld = ($urandom_range(0, 24) == 0);
            cd = ($urandom_range(0, 9) != 0);
            tk = ($urandom_range(0, 2) == 0);
            step(ld, cd, tk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
